branch_logic: RTL and testbench

- Branch-condition evaluator in the EX stage of the RV32IM pipeline.
- Compares the two forwarded register operands under a 3-bit branch opcode and produces a single "take branch / jump" flag.
- The flag is combinational for same-cycle PC redirect.
- A registered copy, and optional statistics counters, are clocked by the pipeline clock.

---
 rtl/branch_logic_pkg.sv | 18 +
 rtl/branch_compare.sv | 17 +
 rtl/branch_logic.sv | 78 +++++++
 tb/tb_branch_logic.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/branch_logic_pkg.sv
// Opcodes and defaults for the RV32IM branch evaluator, shared by the decoder and EX stage.
// Pure declarations: no logic, no latency, no flow control.
package branch_logic_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 32;

  // funct3-aligned so the decoder can pass funct3 straight through for branches
  localparam logic [2:0] BEQ      = 3'b000;
  localparam logic [2:0] BNE      = 3'b001;
  localparam logic [2:0] JAL_JALR = 3'b010;
  localparam logic [2:0] NONE     = 3'b011;
  localparam logic [2:0] BLT      = 3'b100;
  localparam logic [2:0] BGE      = 3'b101;
  localparam logic [2:0] BLTU     = 3'b110;
  localparam logic [2:0] BGEU     = 3'b111;

endpackage

// File: rtl/branch_compare.sv
// Operand comparator: equality, signed less-than and unsigned less-than of data1 vs data2.
// Combinational, zero latency; no backpressure.
module branch_compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            eq,
  output logic            lt_signed,
  output logic            lt_unsigned
);

  assign eq          = (data1 == data2);
  assign lt_signed   = ($signed(data1) < $signed(data2));
  assign lt_unsigned = (data1 < data2);

endmodule

// File: rtl/branch_logic.sv
// Branch-taken evaluator with registered copy; optional counters under BRANCH_STATS_EN.
// out is combinational (0 cycles); out_reg and counters update 1 cycle after en=1.
// No backpressure: en only qualifies the registered/statistics path.
module branch_logic
  import branch_logic_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [2:0]       op,
  output logic             out,
  output logic             out_reg
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] eval_count
`endif
);

  logic eq;
  logic lt_signed;
  logic lt_unsigned;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .data1       (data1),
    .data2       (data2),
    .eq          (eq),
    .lt_signed   (lt_signed),
    .lt_unsigned (lt_unsigned)
  );

  // default arm covers unknown op bits so the redirect never fires spuriously
  always_comb begin
    out = 1'b0;
    case (op)
      BEQ:      out = eq;
      BNE:      out = ~eq;
      JAL_JALR: out = 1'b1;
      NONE:     out = 1'b0;
      BLT:      out = lt_signed;
      BGE:      out = ~lt_signed;
      BLTU:     out = lt_unsigned;
      BGEU:     out = ~lt_unsigned;
      default:  out = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_reg <= 1'b0;
    end else if (en) begin
      out_reg <= out;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else if (en) begin
      eval_count <= eval_count + 1'b1;
      if (out) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: directed test-plan cases plus random cycles vs a reference model.
// Counter checks are active when BRANCH_STATS_EN is defined (counters built 4 bits wide to exercise wrap).
module tb_branch_logic;

  localparam int XLEN = 32;
  localparam int CNT_W = 4;

  logic             CLK;
  logic             RESET;
  logic             en;
  logic [XLEN-1:0]  data1;
  logic [XLEN-1:0]  data2;
  logic [2:0]       op;
  logic             out;
  logic             out_reg;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] eval_count;
`endif

  int errors = 0;
  int checks = 0;

  // reference state
  logic reg_m = 1'b0;
  int   eval_m = 0;
  int   taken_m = 0;

  branch_logic #(
    .XLEN(XLEN)
`ifdef BRANCH_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .en      (en),
    .data1   (data1),
    .data2   (data2),
    .op      (op),
    .out     (out),
    .out_reg (out_reg)
`ifdef BRANCH_STATS_EN
    , .taken_count (taken_count)
    , .eval_count  (eval_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec rules expressed with widened integer arithmetic
  function automatic logic ref_out(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    case (o)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd2: return 1'b1;
      3'd3: return 1'b0;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  // One cycle: drive, check comb out, clock, check registered state
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b);
    logic exp_out;
    RESET = r; en = e; op = o; data1 = a; data2 = b;
    #1;
    exp_out = ref_out(o, a, b);
    check({tag, ".out"}, {31'b0, out}, {31'b0, exp_out});
    @(posedge CLK);
    if (r) begin
      reg_m = 1'b0; eval_m = 0; taken_m = 0;
    end else if (e) begin
      reg_m = exp_out;
      eval_m = (eval_m + 1) % (1 << CNT_W);
      if (exp_out) taken_m = (taken_m + 1) % (1 << CNT_W);
    end
    #1;
    check({tag, ".out_reg"}, {31'b0, out_reg}, {31'b0, reg_m});
`ifdef BRANCH_STATS_EN
    check({tag, ".eval"}, {28'b0, eval_count}, 32'(eval_m));
    check({tag, ".taken"}, {28'b0, taken_count}, 32'(taken_m));
`endif
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t vecs[] = '{
    '{3'b000, 32'h12345678, 32'h12345678, 1'b1},
    '{3'b000, 32'h12345678, 32'h87654321, 1'b0},
    '{3'b001, 32'h12345678, 32'h12345678, 1'b0},
    '{3'b001, 32'h12345678, 32'h87654321, 1'b1},
    '{3'b100, 32'h80000000, 32'h00000001, 1'b1},
    '{3'b100, 32'h00000001, 32'h80000000, 1'b0},
    '{3'b101, 32'h00000001, 32'h80000000, 1'b1},
    '{3'b101, 32'h80000000, 32'h00000001, 1'b0},
    '{3'b100, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0},
    '{3'b101, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1},
    '{3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b1},
    '{3'b110, 32'h00000001, 32'hFFFFFFFF, 1'b1},
    '{3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0},
    '{3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b1},
    '{3'b111, 32'h00000001, 32'hFFFFFFFF, 1'b0},
    '{3'b110, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0},
    '{3'b111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1},
    '{3'b010, 32'h12345678, 32'h87654321, 1'b1},
    '{3'b011, 32'h12345678, 32'h12345678, 1'b0},
    '{3'b011, 32'hFFFFFFFF, 32'h00000000, 1'b0}
  };

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    RESET = 1'b1; en = 1'b0; op = 3'b000; data1 = '0; data2 = '0;

    // reset state
    @(posedge CLK); #1;
    check("reset.out_reg", {31'b0, out_reg}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("reset.eval", {28'b0, eval_count}, 32'd0);
    check("reset.taken", {28'b0, taken_count}, 32'd0);
`endif
    RESET = 1'b0;

    // combinational truth table, en low so registered state is untouched
    foreach (vecs[i]) begin
      op = vecs[i].o; data1 = vecs[i].a; data2 = vecs[i].b;
      #1;
      check($sformatf("comb[%0d]", i), {31'b0, out}, {31'b0, vecs[i].exp});
    end

    // registered path
    step("reg.beq_en", 1'b0, 1'b1, 3'b000, 32'h5, 32'h5);
    check("reg.beq_en.const", {31'b0, out_reg}, 32'd1);
    step("reg.bne_hold", 1'b0, 1'b0, 3'b001, 32'h5, 32'h5);
    check("reg.bne_hold.const", {31'b0, out_reg}, 32'd1);
    step("reg.reset", 1'b1, 1'b1, 3'b000, 32'h9, 32'h9);
    check("reg.reset.const", {31'b0, out_reg}, 32'd0);
    check("reg.reset.out_tracks", {31'b0, out}, 32'd1);

`ifdef BRANCH_STATS_EN
    // 5 evaluations, 3 taken, plus 2 idle cycles
    step("st.a", 1'b0, 1'b1, 3'b000, 32'h1, 32'h1);
    step("st.b", 1'b0, 1'b1, 3'b010, 32'h1, 32'h2);
    step("st.c", 1'b0, 1'b1, 3'b011, 32'h1, 32'h2);
    step("st.idle0", 1'b0, 1'b0, 3'b010, 32'h1, 32'h2);
    step("st.d", 1'b0, 1'b1, 3'b001, 32'h3, 32'h3);
    step("st.idle1", 1'b0, 1'b0, 3'b010, 32'h1, 32'h2);
    step("st.e", 1'b0, 1'b1, 3'b110, 32'h1, 32'h2);
    check("st.eval5", {28'b0, eval_count}, 32'd5);
    check("st.taken3", {28'b0, taken_count}, 32'd3);
    step("wr.reset", 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int k = 0; k < 17; k++) step("wr.jal", 1'b0, 1'b1, 3'b010, 32'h12345678, 32'h87654321);
    check("wr.eval1", {28'b0, eval_count}, 32'd1);
    check("wr.taken1", {28'b0, taken_count}, 32'd1);
`endif

    // random cycles, with operand shaping to hit equality and sign boundaries
    for (int n = 0; n < 300; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: begin ra = 32'h80000000; rb = $urandom; end
        2: begin ra = $urandom; rb = 32'h7FFFFFFF; end
        3: rb = ra ^ 32'h80000000;
        default: rb = $urandom;
      endcase
      step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
